// File: rtl/trig_dly_pkg.sv
// Shared types and default sizing for the trigger delay/gate controller.
package trig_dly_pkg;

  localparam int unsigned NCH_DEF = 8;
  localparam int unsigned DW_DEF  = 4;
  localparam int unsigned WW_DEF  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StGate
  } chan_state_e;

  typedef struct packed {
    logic [DW_DEF-1:0] delay;
    logic [WW_DEF-1:0] width;
    logic              retrig;
  } chan_cfg_t;

endpackage

// File: rtl/trig_dly_chan.sv
// One trigger channel: edge detect, IDLE/DELAY/GATE sequencer, counters and sticky missed flag.
// Define TRIG_DLY_SYNC_EN to put a two-flop synchronizer ahead of the edge detector.
module trig_dly_chan
  import trig_dly_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned WW = WW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hit,
  input  logic [DW-1:0] cfg_delay,
  input  logic [WW-1:0] cfg_width,
  input  logic          cfg_retrig,
  input  logic          clr_missed,
  output logic          gate,
  output logic          busy,
  output logic          missed
);

  logic hit_s;

`ifdef TRIG_DLY_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], hit};
  end
  assign hit_s = sync_q[1];
`else
  assign hit_s = hit;
`endif

  chan_state_e   state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [WW-1:0] width_q, width_d;
  logic          retrig_q, retrig_d;
  logic          missed_q, missed_d;
  logic          prev_q;
  logic          rise;
  logic          miss_set;

  // prev resets high so a level already high at reset release is not an edge
  assign rise = hit_s & ~prev_q;

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    wcnt_d   = wcnt_q;
    width_d  = width_q;
    retrig_d = retrig_q;
    miss_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise && (cfg_width != '0)) begin
          width_d  = cfg_width;
          retrig_d = cfg_retrig;
          if (cfg_delay == '0) begin
            state_d = StGate;
            wcnt_d  = cfg_width;
          end else begin
            state_d = StDelay;
            dcnt_d  = cfg_delay;
          end
        end
      end
      StDelay: begin
        miss_set = rise;
        if (dcnt_q == DW'(1)) begin
          state_d = StGate;
          wcnt_d  = width_q;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      StGate: begin
        if (rise && retrig_q) begin
          wcnt_d = width_q;
        end else begin
          miss_set = rise;
          if (wcnt_q == WW'(1)) state_d = StIdle;
          else                  wcnt_d  = wcnt_q - WW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // a config write clearing the flag beats a simultaneous rejection
    if (clr_missed)    missed_d = 1'b0;
    else if (miss_set) missed_d = 1'b1;
    else               missed_d = missed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dcnt_q   <= '0;
      wcnt_q   <= '0;
      width_q  <= '0;
      retrig_q <= 1'b0;
      missed_q <= 1'b0;
      prev_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      wcnt_q   <= wcnt_d;
      width_q  <= width_d;
      retrig_q <= retrig_d;
      missed_q <= missed_d;
      prev_q   <= hit_s;
    end
  end

  assign gate   = (state_q == StGate);
  assign busy   = (state_q != StIdle);
  assign missed = missed_q;

endmodule

// File: rtl/trig_delay_ctrl.sv
// Multi-channel trigger delay/gate controller: config register file, write decode, cfg_ack.
// Optional TRIG_DLY_SYNC_EN adds hit input synchronizers inside each channel.
module trig_delay_ctrl
  import trig_dly_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned WW  = WW_DEF,
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] hit_in,
  input  logic           cfg_wr,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_delay,
  input  logic [WW-1:0]  cfg_width,
  input  logic           cfg_retrig,
  output logic           cfg_ack,
  output logic [NCH-1:0] gate_out,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] missed
);

  logic [DW-1:0]  delay_q [NCH];
  logic [WW-1:0]  width_q [NCH];
  logic [NCH-1:0] retrig_q;
  logic [NCH-1:0] wr_sel;
  logic           ack_q;

  // out-of-range channels select nothing but are still acknowledged
  always_comb begin
    wr_sel = '0;
    if (cfg_wr && (32'(cfg_ch) < NCH)) wr_sel[cfg_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        delay_q[i] <= '0;
        width_q[i] <= '0;
      end
      retrig_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= cfg_wr;
      for (int i = 0; i < NCH; i++) begin
        if (wr_sel[i]) begin
          delay_q[i]  <= cfg_delay;
          width_q[i]  <= cfg_width;
          retrig_q[i] <= cfg_retrig;
        end
      end
    end
  end

  assign cfg_ack = ack_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    trig_dly_chan #(
      .DW (DW),
      .WW (WW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .hit        (hit_in[i]),
      .cfg_delay  (delay_q[i]),
      .cfg_width  (width_q[i]),
      .cfg_retrig (retrig_q[i]),
      .clr_missed (wr_sel[i]),
      .gate       (gate_out[i]),
      .busy       (busy[i]),
      .missed     (missed[i])
    );
  end

endmodule

// File: doc/trig_delay_ctrl.md
# trig_delay_ctrl

Programmable multi-channel delay/gate controller for the MUSE trigger LUT front end. Each channel detects a rising edge on its hit input, waits a per-channel programmed delay, and then asserts a gate output for a programmed width. Per channel, retriggering either extends the gate or is rejected and flagged. Configuration arrives over a simple single-cycle write port. The block sits between the discriminated hit inputs and the LUT coincidence logic, and replaces fixed-stage delay chains with a sequenced, runtime-configurable scheme.

## Interface
- NCH, 8, number of trigger channels
- DW, 4, delay counter width; delay range 0..2^DW-1 cycles
- WW, 4, gate-width counter width; width 0 disables the channel
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- hit_in  in  NCH  hit levels, synchronous to clk unless TRIG_DLY_SYNC_EN is defined
- cfg_wr  in  1  config write strobe, single cycle
- cfg_ch  in  $clog2(NCH)  target channel
- cfg_delay  in  DW  delay value
- cfg_width  in  WW  gate width
- cfg_retrig  in  1  1 = an edge during GATE extends the gate
- cfg_ack  out  1  pulses for one cycle, the cycle after cfg_wr
- gate_out  out  NCH  delayed gate per channel
- busy  out  NCH  channel is in DELAY or GATE
- missed  out  NCH  sticky flag: an edge was rejected; cleared by a cfg write to that channel

## Operation
- Reset values:
  - gate_out=0, busy=0, missed=0, cfg_ack=0.
  - All channels in IDLE. Config registers delay=0, width=0, retrig=0, so every channel is disabled.
  - Edge-detect previous-value flops reset to 1, so an input held high through reset release does not fire.
- Edge: hit_in[i]=1 sampled while the previous sample was 0. Evaluated every cycle.
- Per-channel FSM, with states IDLE, DELAY, GATE:
  - IDLE, edge, width≠0: latch the active copy of delay, width and retrig. Go to DELAY with dcnt=delay, or go directly to GATE if delay=0.
  - IDLE, edge, width=0: ignored. missed is not set.
  - DELAY: dcnt decrements each cycle; at dcnt==1 go to GATE. Any edge is ignored and sets missed.
  - GATE: gate_out=1 and wcnt loads the latched width, then decrements; at wcnt==1 go to IDLE.
    - Edge with latched retrig=1: reload wcnt=width. The gate stays high until `width` cycles after the retrigger edge.
    - Edge with latched retrig=0: ignored; sets missed.
- Config write:
  - Updates the channel's config registers and clears missed[cfg_ch] the cycle after cfg_wr.
  - An in-flight trigger keeps its latched copy; the new values apply from the next IDLE edge.
  - cfg_wr with cfg_ch ≥ NCH: ignored, but cfg_ack still pulses.
- Simultaneous events:
  - Edge and cfg write to the same channel in the same cycle: the edge uses the old values, and missed clears.
  - Edge and missed-set with a cfg clear in the same cycle: the clear wins.
- Reset asserted mid-operation: all channels return to IDLE immediately and gate_out drops asynchronously.

## Timing
- Edge sampled at cycle E:
  - delay=D≥1: gate_out rises at E+1+D.
  - delay=0: gate_out rises at E+1.
- Gate high for exactly W cycles when there is no retrigger.
- busy rises at E+1 and falls with gate_out.
- Back-to-back triggers: an edge sampled in the cycle gate_out falls (FSM in IDLE) is accepted, so the minimum IDLE gap is 0 cycles.
- cfg_ack is at cfg_wr+1. The new config is visible to an edge sampled at cfg_wr+1 or later.

## Configuration
- TRIG_DLY_SYNC_EN:
  - Defined: a two-flop synchronizer on each hit_in bit ahead of edge detection. All edge-relative latencies grow by 2 cycles, and synchronizer flops reset to 1.
  - Undefined: hit_in feeds edge detection directly and no synchronizer flops are present.

## Structure
- Package trig_dly_pkg:
  - State enum (IDLE, DELAY, GATE).
  - Default NCH/DW/WW localparams.
  - Channel config struct {delay, width, retrig}.
- Sub-module trig_dly_chan: one channel's edge detect, FSM, counters and missed flag. It is instantiated NCH times in a generate loop.
- The top level holds the config register file, address decode and cfg_ack.

## Test plan
- Channel 0 set to delay=3, width=2; hit rises at E -> gate_out[0] high at E+4 and E+5, low at E+6; missed=0.
- Channel 1 set to delay=0, width=4, retrig=1; edges at E and E+2 -> gate_out[1] high from E+1 through E+6.
- Channel 2 set to delay=5, width=1, retrig=0; edges at E and E+2 -> one gate at E+6; missed[2]=1, cleared by a cfg write to channel 2.
- Reset: a channel in default config (width=0) with hit pulsing -> gate_out stays 0, busy stays 0.
- rst_n deasserted with hit_in held high -> no gate.
- Cfg write to channel 3 (delay 2→6) in the same cycle as its edge -> the gate uses delay 2; the next trigger uses delay 6; cfg_ack one cycle after cfg_wr.
- rst_n asserted during GATE -> gate_out drops immediately; after release the channel is in IDLE and config is at reset defaults.
